// File: rtl/fifo_wr_ingress_if.sv
// fifo_wr_ingress_if: valid/ready producer stream into the FIFO write ingress.
//   s_valid  producer word valid
//   s_data   producer word
//   s_ready  ingress can accept a word this cycle
interface fifo_wr_ingress_if #(
    parameter int DATA_SIZE = 8
);
    logic                 s_valid;
    logic [DATA_SIZE-1:0] s_data;
    logic                 s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/fifo_wr_ingress.sv
// fifo_wr_ingress: write-side ingress of the async FIFO; skid-buffers a valid/ready
// stream into the wr_inc/wr_data strobe and reports write-domain fill level.
//   wr_clk, wr_rst   write clock, asynchronous active-low reset
//   s                producer stream (slave modport)
//   wr_full          registered full flag from the write-pointer stage
//   wr_ptr           registered gray write pointer
//   wr_q2_rptr       gray read pointer synchronized into wr_clk
//   wr_inc, wr_data  write strobe and word to memory
//   wr_level         registered occupancy, wr_almost_full registered level >= AF_THRESH
//   wr_ptr_err       sticky flag for a pointer distance beyond the FIFO depth
module fifo_wr_ingress #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 4,
    parameter int AF_THRESH = 12
) (
    input  logic                   wr_clk,
    input  logic                   wr_rst,
    fifo_wr_ingress_if.slave       s,
    input  logic                   wr_full,
    input  logic [ADDR_SIZE:0]     wr_ptr,
    input  logic [ADDR_SIZE:0]     wr_q2_rptr,
    output logic                   wr_inc,
    output logic [DATA_SIZE-1:0]   wr_data,
    output logic [ADDR_SIZE:0]     wr_level,
    output logic                   wr_almost_full,
    output logic                   wr_ptr_err
);
    localparam int PTR_W = ADDR_SIZE + 1;
    localparam logic [PTR_W-1:0] DEPTH = PTR_W'(2 ** ADDR_SIZE);
    localparam logic [PTR_W-1:0] AF    = PTR_W'(AF_THRESH);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t               state_q, state_d;
    logic [DATA_SIZE-1:0] head_q, head_d, skid_q, skid_d;
    logic                 ready_q, ready_d;
    logic [PTR_W-1:0]     level_q, level_d;
    logic                 af_q, af_d, err_q, err_d;
    logic                 accept, pop;
    logic [PTR_W-1:0]     diff;

    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b = g;
        for (int i = PTR_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    assign accept = s.s_valid & ready_q;
    assign pop    = (state_q != EMPTY) & ~wr_full;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: if (accept) begin
                state_d = ONE;
                head_d  = s.s_data;
            end
            ONE: if (accept & pop) begin
                head_d  = s.s_data;
            end else if (accept) begin
                state_d = TWO;
                skid_d  = s.s_data;
            end else if (pop) begin
                state_d = EMPTY;
            end
            TWO: if (pop) begin
                state_d = ONE;
                head_d  = skid_q;
            end
            default: state_d = EMPTY;
        endcase
        ready_d = state_d != TWO;
    end

    // Modular subtraction keeps the distance correct across pointer wrap.
    always_comb begin
        diff    = gray2bin(wr_ptr) - gray2bin(wr_q2_rptr);
        level_d = diff;
        af_d    = diff >= AF;
        err_d   = err_q | (diff > DEPTH);
    end

    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
            level_q <= '0;
            af_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            level_q <= level_d;
            af_q    <= af_d;
            err_q   <= err_d;
        end
    end

    assign s.s_ready      = ready_q;
    assign wr_inc         = pop;
    assign wr_data        = head_q;
    assign wr_level       = level_q;
    assign wr_almost_full = af_q;
    assign wr_ptr_err     = err_q;
endmodule

// File: tb/tb_fifo_wr_ingress.sv
// tb_fifo_wr_ingress: directed and random checks of fifo_wr_ingress with a write-order scoreboard.
module tb_fifo_wr_ingress;
    logic       wr_clk = 1'b0;
    logic       wr_rst = 1'b1;
    logic       wr_full = 1'b0;
    logic [4:0] wr_ptr = '0, wr_q2_rptr = '0;
    logic       wr_inc, wr_almost_full, wr_ptr_err;
    logic [7:0] wr_data;
    logic [4:0] wr_level;
    int         n_tests = 0, n_fail = 0;
    logic [7:0] exp_q[$];

    fifo_wr_ingress_if #(.DATA_SIZE(8)) s_if ();

    fifo_wr_ingress #(.DATA_SIZE(8), .ADDR_SIZE(4), .AF_THRESH(12)) dut (
        .wr_clk(wr_clk), .wr_rst(wr_rst), .s(s_if), .wr_full(wr_full),
        .wr_ptr(wr_ptr), .wr_q2_rptr(wr_q2_rptr), .wr_inc(wr_inc), .wr_data(wr_data),
        .wr_level(wr_level), .wr_almost_full(wr_almost_full), .wr_ptr_err(wr_ptr_err)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 32'(s_if.s_ready), 0);
        chk({tag, "_inc"}, 32'(wr_inc), 0);
        chk({tag, "_data"}, 32'(wr_data), 0);
        chk({tag, "_level"}, 32'(wr_level), 0);
        chk({tag, "_af"}, 32'(wr_almost_full), 0);
        chk({tag, "_err"}, 32'(wr_ptr_err), 0);
    endtask

    task automatic lvl(input logic [4:0] wp, input logic [4:0] rp, input int level,
                       input logic af, input logic err);
        wr_ptr = wp;
        wr_q2_rptr = rp;
        tick();
        chk("level", 32'(wr_level), 32'(level));
        chk("almost_full", 32'(wr_almost_full), 32'(af));
        chk("ptr_err", 32'(wr_ptr_err), 32'(err));
    endtask

    // Scoreboard: every memory write must be the oldest accepted, unwritten word.
    always @(negedge wr_rst) exp_q.delete();
    always @(negedge wr_clk) begin
        if (wr_rst) begin
            if (wr_inc && !wr_full) begin
                if (exp_q.size() == 0) chk("sb_extra_write", 1, 0);
                else chk("sb_data", 32'(wr_data), 32'(exp_q.pop_front()));
            end
            if (s_if.s_valid && s_if.s_ready) exp_q.push_back(s_if.s_data);
        end
    end

    initial begin
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        #2 wr_rst = 1'b0;
        #1 chk_zero("rst0");
        @(negedge wr_clk) wr_rst = 1'b1;
        tick();
        chk("ready_after_rst", 32'(s_if.s_ready), 1);
        chk("inc_idle", 32'(wr_inc), 0);

        // Streaming 0x00..0x0F at one word per cycle.
        s_if.s_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_if.s_data = 8'(i);
            tick();
            chk("stream_inc", 32'(wr_inc), 1);
            chk("stream_data", 32'(wr_data), 32'(i));
        end
        s_if.s_valid = 1'b0;
        tick();
        chk("stream_end_inc", 32'(wr_inc), 0);

        // Backpressure: A0 written, A1 held in head, A2 in skid.
        s_if.s_valid = 1'b1;
        s_if.s_data = 8'hA0;
        tick();
        chk("bp_a0", 32'(wr_data), 32'hA0);
        s_if.s_data = 8'hA1;
        tick();
        s_if.s_data = 8'hA2;
        wr_full = 1'b1;
        tick();
        s_if.s_valid = 1'b0;
        chk("bp_ready", 32'(s_if.s_ready), 0);
        chk("bp_hold_data", 32'(wr_data), 32'hA1);
        chk("bp_hold_inc", 32'(wr_inc), 0);
        tick();
        chk("bp_hold2_data", 32'(wr_data), 32'hA1);
        chk("bp_hold2_ready", 32'(s_if.s_ready), 0);
        wr_full = 1'b0;
        #1 chk("bp_rel_inc", 32'(wr_inc), 1);
        chk("bp_rel_data", 32'(wr_data), 32'hA1);
        tick();
        chk("bp_a2_data", 32'(wr_data), 32'hA2);
        chk("bp_a2_inc", 32'(wr_inc), 1);
        chk("bp_a2_ready", 32'(s_if.s_ready), 1);
        tick();
        chk("bp_drain_inc", 32'(wr_inc), 0);

        // Level, wrap, almost-full edges, depth boundary, then sticky error.
        lvl(5'b00010, 5'b10001, 5, 0, 0);
        lvl(5'b01001, 5'b00000, 14, 1, 0);
        lvl(5'b01010, 5'b00000, 12, 1, 0);
        lvl(5'b01110, 5'b00000, 11, 0, 0);
        lvl(5'b11000, 5'b00000, 16, 1, 0);
        lvl(5'b11110, 5'b00011, 18, 1, 1);
        lvl(5'b00000, 5'b00000, 0, 0, 1);

        // Reset with two words buffered: both must be discarded.
        wr_full = 1'b1;
        s_if.s_valid = 1'b1;
        s_if.s_data = 8'h55;
        tick();
        s_if.s_data = 8'h66;
        tick();
        s_if.s_valid = 1'b0;
        chk("two_ready", 32'(s_if.s_ready), 0);
        wr_full = 1'b0;
        wr_rst = 1'b0;
        #1 chk_zero("rst_mid");
        tick();
        @(negedge wr_clk) wr_rst = 1'b1;
        tick();
        chk("rst_mid_ready", 32'(s_if.s_ready), 1);
        chk("rst_mid_inc", 32'(wr_inc), 0);
        chk("rst_mid_data", 32'(wr_data), 0);

        // Random traffic under random backpressure.
        for (int c = 0; c < 10000; c++) begin
            s_if.s_valid = 1'($urandom_range(0, 1));
            s_if.s_data = 8'($urandom);
            wr_full = ($urandom_range(0, 3) == 0);
            tick();
        end
        s_if.s_valid = 1'b0;
        wr_full = 1'b0;
        repeat (4) tick();
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
